// File: rtl/gpfc_pause_generator_if.sv
// GPFC pause source interface: enqueue/dequeue events in, pause rank and occupancy status out.
interface gpfc_pause_generator_if #(
    parameter int unsigned BUFFER_ADDR_WIDTH = 12,
    parameter int unsigned PIFO_RANK_WIDTH   = 18
);
    logic                         s_axis_enq_valid;
    logic                         s_axis_deq_valid;
    logic                         m_axis_gpfc_valid;
    logic [PIFO_RANK_WIDTH-1:0]   m_axis_gpfc_pause_rank;
    logic [BUFFER_ADDR_WIDTH:0]   m_axis_occupancy;
    logic                         m_axis_occ_error;

    modport master (
        output s_axis_enq_valid,
        output s_axis_deq_valid,
        input  m_axis_gpfc_valid,
        input  m_axis_gpfc_pause_rank,
        input  m_axis_occupancy,
        input  m_axis_occ_error
    );

    modport slave (
        input  s_axis_enq_valid,
        input  s_axis_deq_valid,
        output m_axis_gpfc_valid,
        output m_axis_gpfc_pause_rank,
        output m_axis_occupancy,
        output m_axis_occ_error
    );
endinterface

// File: rtl/gpfc_pause_generator.sv
// Buffer occupancy tracker that issues a GPFC pause rank, tightened/relaxed stepwise
// on a fixed update interval with XOFF/XON hysteresis.
module gpfc_pause_generator #(
    parameter int unsigned BUFFER_ADDR_WIDTH = 12,
    parameter int unsigned PIFO_RANK_WIDTH   = 18,
    parameter int unsigned XOFF_THRESH       = 3072,
    parameter int unsigned XON_THRESH        = 2048,
    parameter int unsigned PAUSE_RANK_INIT   = 196608,
    parameter int unsigned PAUSE_RANK_MIN    = 0,
    parameter int unsigned RANK_STEP         = 4096,
    parameter int unsigned UPDATE_INTERVAL   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    gpfc_pause_generator_if.slave bus
);
    localparam int unsigned OCC_W = BUFFER_ADDR_WIDTH + 1;
    localparam int unsigned EXT_W = PIFO_RANK_WIDTH + 1;
    localparam int unsigned CNT_W = (UPDATE_INTERVAL > 1) ? $clog2(UPDATE_INTERVAL) : 1;

    localparam logic [OCC_W-1:0] OCC_FULL = {1'b1, {BUFFER_ADDR_WIDTH{1'b0}}};
    localparam logic [OCC_W-1:0] XOFF_OCC = OCC_W'(XOFF_THRESH);
    localparam logic [OCC_W-1:0] XON_OCC  = OCC_W'(XON_THRESH);
    localparam logic [EXT_W-1:0] MIN_X    = EXT_W'(PAUSE_RANK_MIN);
    localparam logic [EXT_W-1:0] STEP_X   = EXT_W'(RANK_STEP);
    localparam logic [EXT_W-1:0] INIT_X   = EXT_W'(PAUSE_RANK_INIT);
    localparam logic [PIFO_RANK_WIDTH-1:0] RANK_INIT = PIFO_RANK_WIDTH'(PAUSE_RANK_INIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UPDATE_INTERVAL - 1);

    typedef enum logic [0:0] {IDLE, PAUSE} state_t;

    state_t                      state;
    logic [CNT_W-1:0]            cnt;
    logic                        gpfc_valid;
    logic [PIFO_RANK_WIDTH-1:0]  pause_rank;
    logic [OCC_W-1:0]            occ;
    logic                        occ_error;

    logic                        tick;
    logic                        over_xoff;
    logic                        under_xon;
    logic [EXT_W-1:0]            rank_x;
    logic [EXT_W-1:0]            dec_x;
    logic [EXT_W-1:0]            inc_x;

    // Occupancy counter; a lone enq at full or lone deq at empty is refused and flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ       <= '0;
            occ_error <= 1'b0;
        end else begin
            case ({bus.s_axis_enq_valid, bus.s_axis_deq_valid})
                2'b10: begin
                    if (occ == OCC_FULL) occ_error <= 1'b1;
                    else                 occ       <= occ + OCC_W'(1);
                end
                2'b01: begin
                    if (occ == '0) occ_error <= 1'b1;
                    else           occ       <= occ - OCC_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Next tightened/relaxed rank, computed one bit wider so neither direction wraps.
    always_comb begin
        rank_x = {1'b0, pause_rank};
        dec_x  = (rank_x < MIN_X + STEP_X) ? MIN_X : rank_x - STEP_X;
        inc_x  = rank_x + STEP_X;
        if (inc_x > INIT_X) inc_x = INIT_X;
    end

    assign tick      = (cnt == CNT_LAST);
    assign over_xoff = (occ >= XOFF_OCC);
    assign under_xon = (occ < XON_OCC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            gpfc_valid <= 1'b0;
            pause_rank <= '1;
        end else begin
            case (state)
                IDLE: begin
                    cnt        <= '0;
                    gpfc_valid <= 1'b0;
                    pause_rank <= '1;
                    if (over_xoff) begin
                        state      <= PAUSE;
                        gpfc_valid <= 1'b1;
                        pause_rank <= RANK_INIT;
                    end
                end
                PAUSE: begin
                    if (tick) begin
                        cnt <= '0;
                        if (over_xoff) begin
                            pause_rank <= PIFO_RANK_WIDTH'(dec_x);
                        end else if (under_xon) begin
                            // Fully relaxed back to the entry rank: release the pause.
                            if (pause_rank == RANK_INIT) begin
                                state      <= IDLE;
                                gpfc_valid <= 1'b0;
                                pause_rank <= '1;
                            end else begin
                                pause_rank <= PIFO_RANK_WIDTH'(inc_x);
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.m_axis_gpfc_valid      = gpfc_valid;
    assign bus.m_axis_gpfc_pause_rank = pause_rank;
    assign bus.m_axis_occupancy       = occ;
    assign bus.m_axis_occ_error       = occ_error;
endmodule

// File: tb/tb_gpfc_pause_generator.sv
// Directed bench for gpfc_pause_generator: default build plus a small coarse-step,
// interval-1 build for floor/relax corner cases.
module tb_gpfc_pause_generator;
    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   pe;

    localparam logic [31:0] RANK_ONES = 32'h3FFFF;

    gpfc_pause_generator_if #(.BUFFER_ADDR_WIDTH(12), .PIFO_RANK_WIDTH(18)) m_if ();
    gpfc_pause_generator_if #(.BUFFER_ADDR_WIDTH(4),  .PIFO_RANK_WIDTH(18)) s_if ();

    gpfc_pause_generator u_dut (
        .clk (clk),
        .rst (rst),
        .bus (m_if.slave)
    );

    gpfc_pause_generator #(
        .BUFFER_ADDR_WIDTH(4),
        .PIFO_RANK_WIDTH  (18),
        .XOFF_THRESH      (12),
        .XON_THRESH       (8),
        .PAUSE_RANK_INIT  (196608),
        .PAUSE_RANK_MIN   (0),
        .RANK_STEP        (100000),
        .UPDATE_INTERVAL  (1)
    ) u_small (
        .clk (clk),
        .rst (rst),
        .bus (s_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Main instance: apply n cycles of the given events, advancing the pause-edge counter.
    task automatic run(input int n, input logic e, input logic d);
        for (int i = 0; i < n; i++) begin
            m_if.s_axis_enq_valid = e;
            m_if.s_axis_deq_valid = d;
            @(posedge clk);
            #1;
            pe++;
        end
        m_if.s_axis_enq_valid = 1'b0;
        m_if.s_axis_deq_valid = 1'b0;
    endtask

    task automatic run_to(input int t, input logic e, input logic d);
        run(t - pe, e, d);
    endtask

    task automatic run_s(input int n, input logic e, input logic d);
        for (int i = 0; i < n; i++) begin
            s_if.s_axis_enq_valid = e;
            s_if.s_axis_deq_valid = d;
            @(posedge clk);
            #1;
        end
        s_if.s_axis_enq_valid = 1'b0;
        s_if.s_axis_deq_valid = 1'b0;
    endtask

    task automatic main_fill_to_pause(input string tag, input int n_enq);
        run(n_enq - 1, 1'b1, 1'b0);
        run(1, 1'b1, 1'b0);
        check({tag, "_occ"},        32'(m_if.m_axis_occupancy), 32'd3072);
        check({tag, "_valid_edge1"}, 32'(m_if.m_axis_gpfc_valid), 32'd0);
        run(1, 1'b0, 1'b0);
        check({tag, "_valid_edge2"}, 32'(m_if.m_axis_gpfc_valid), 32'd1);
        check({tag, "_rank_init"},   32'(m_if.m_axis_gpfc_pause_rank), 32'd196608);
        pe = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        pe     = 0;
        m_if.s_axis_enq_valid = 1'b0;
        m_if.s_axis_deq_valid = 1'b0;
        s_if.s_axis_enq_valid = 1'b0;
        s_if.s_axis_deq_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(m_if.m_axis_gpfc_valid), 32'd0);
        check("rst_rank",  32'(m_if.m_axis_gpfc_pause_rank), RANK_ONES);
        check("rst_occ",   32'(m_if.m_axis_occupancy), 32'd0);
        check("rst_err",   32'(m_if.m_axis_occ_error), 32'd0);
        check("rst_s_rank", 32'(s_if.m_axis_gpfc_pause_rank), RANK_ONES);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Small build: underflow, fast tighten to floor, relax back and release.
        run_s(1, 1'b0, 1'b1);
        check("s_underflow_occ", 32'(s_if.m_axis_occupancy), 32'd0);
        check("s_underflow_err", 32'(s_if.m_axis_occ_error), 32'd1);
        run_s(12, 1'b1, 1'b0);
        check("s_fill_valid0", 32'(s_if.m_axis_gpfc_valid), 32'd0);
        run_s(1, 1'b0, 1'b0);
        check("s_enter_valid", 32'(s_if.m_axis_gpfc_valid), 32'd1);
        check("s_enter_rank",  32'(s_if.m_axis_gpfc_pause_rank), 32'd196608);
        run_s(1, 1'b0, 1'b0);
        check("s_tight1", 32'(s_if.m_axis_gpfc_pause_rank), 32'd96608);
        run_s(1, 1'b0, 1'b0);
        check("s_tight2_floor", 32'(s_if.m_axis_gpfc_pause_rank), 32'd0);
        run_s(1, 1'b0, 1'b0);
        check("s_floor_hold", 32'(s_if.m_axis_gpfc_pause_rank), 32'd0);
        run_s(5, 1'b0, 1'b1);
        check("s_drain_occ",  32'(s_if.m_axis_occupancy), 32'd7);
        check("s_drain_rank", 32'(s_if.m_axis_gpfc_pause_rank), 32'd0);
        run_s(1, 1'b0, 1'b0);
        check("s_relax1", 32'(s_if.m_axis_gpfc_pause_rank), 32'd100000);
        run_s(1, 1'b0, 1'b0);
        check("s_relax2_cap", 32'(s_if.m_axis_gpfc_pause_rank), 32'd196608);
        check("s_relax2_valid", 32'(s_if.m_axis_gpfc_valid), 32'd1);
        run_s(1, 1'b0, 1'b0);
        check("s_release_valid", 32'(s_if.m_axis_gpfc_valid), 32'd0);
        check("s_release_rank",  32'(s_if.m_axis_gpfc_pause_rank), RANK_ONES);

        // Main build: enter pause, tighten twice at occupancy 3100.
        main_fill_to_pause("entry", 3072);
        run(28, 1'b1, 1'b0);
        run_to(63, 1'b0, 1'b0);
        check("pre_tick_rank", 32'(m_if.m_axis_gpfc_pause_rank), 32'd196608);
        run_to(64, 1'b0, 1'b0);
        check("tick1_rank", 32'(m_if.m_axis_gpfc_pause_rank), 32'd192512);
        run_to(127, 1'b0, 1'b0);
        check("between_ticks", 32'(m_if.m_axis_gpfc_pause_rank), 32'd192512);
        run_to(128, 1'b0, 1'b0);
        check("tick2_rank", 32'(m_if.m_axis_gpfc_pause_rank), 32'd188416);
        check("hold_occ",   32'(m_if.m_axis_occupancy), 32'd3100);

        // Drain toward 2000: hold ticks until occupancy falls under XON, then relax and release.
        run_to(1215, 1'b0, 1'b1);
        check("drain_hold_rank", 32'(m_if.m_axis_gpfc_pause_rank), 32'd188416);
        run_to(1216, 1'b0, 1'b1);
        check("relax1_rank", 32'(m_if.m_axis_gpfc_pause_rank), 32'd192512);
        run_to(1228, 1'b0, 1'b1);
        check("drain_occ", 32'(m_if.m_axis_occupancy), 32'd2000);
        run_to(1279, 1'b0, 1'b0);
        check("relax_wait", 32'(m_if.m_axis_gpfc_pause_rank), 32'd192512);
        run_to(1280, 1'b0, 1'b0);
        check("relax2_rank",  32'(m_if.m_axis_gpfc_pause_rank), 32'd196608);
        check("relax2_valid", 32'(m_if.m_axis_gpfc_valid), 32'd1);
        run_to(1343, 1'b0, 1'b0);
        check("pre_release_valid", 32'(m_if.m_axis_gpfc_valid), 32'd1);
        run_to(1344, 1'b0, 1'b0);
        check("release_valid", 32'(m_if.m_axis_gpfc_valid), 32'd0);
        check("release_rank",  32'(m_if.m_axis_gpfc_pause_rank), RANK_ONES);

        // Re-enter from 2000, then sit in the hysteresis band at 2500.
        main_fill_to_pause("reentry", 1072);
        run(572, 1'b0, 1'b1);
        run_to(900, 1'b0, 1'b0);
        check("band_occ",   32'(m_if.m_axis_occupancy), 32'd2500);
        check("band_rank",  32'(m_if.m_axis_gpfc_pause_rank), 32'd196608);
        check("band_valid", 32'(m_if.m_axis_gpfc_valid), 32'd1);

        // Saturation at full capacity.
        run(1596, 1'b1, 1'b0);
        check("full_occ", 32'(m_if.m_axis_occupancy), 32'd4096);
        check("full_err", 32'(m_if.m_axis_occ_error), 32'd0);
        run(3, 1'b1, 1'b0);
        check("overflow_occ", 32'(m_if.m_axis_occupancy), 32'd4096);
        check("overflow_err", 32'(m_if.m_axis_occ_error), 32'd1);
        run(2, 1'b1, 1'b1);
        check("full_both_occ", 32'(m_if.m_axis_occupancy), 32'd4096);
        check("pre_rst_valid", 32'(m_if.m_axis_gpfc_valid), 32'd1);

        // Asynchronous reset mid-pause, between edges.
        #2;
        rst = 1'b1;
        #1;
        check("async_valid", 32'(m_if.m_axis_gpfc_valid), 32'd0);
        check("async_occ",   32'(m_if.m_axis_occupancy), 32'd0);
        check("async_rank",  32'(m_if.m_axis_gpfc_pause_rank), RANK_ONES);
        check("async_err",   32'(m_if.m_axis_occ_error), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        main_fill_to_pause("refill", 3072);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gpfc_pause_generator.md
Name: gpfc_pause_generator

Overview:
- Source side of the GPFC pause interface consumed by the output-queue bypass path.
- Tracks buffer occupancy from enqueue/dequeue events.
- Asserts a pause with a pause rank: packets with rank >= pause rank are held.
- Tightens or relaxes the pause rank stepwise on a fixed update interval, with XOFF/XON hysteresis.

Parameters:
BUFFER_ADDR_WIDTH, 12, buffer address width; capacity = 2^BUFFER_ADDR_WIDTH entries
PIFO_RANK_WIDTH, 18, rank width
XOFF_THRESH, 3072, occupancy at/above which pausing starts or tightens
XON_THRESH, 2048, occupancy below which pausing relaxes; must be < XOFF_THRESH
PAUSE_RANK_INIT, 196608, first pause rank issued on entering pause
PAUSE_RANK_MIN, 0, floor for pause rank
RANK_STEP, 4096, pause rank change per update tick
UPDATE_INTERVAL, 64, cycles between rank updates while paused (>= 1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_axis_enq_valid  in  1  one entry enqueued this cycle
s_axis_deq_valid  in  1  one entry dequeued this cycle
m_axis_gpfc_valid  out  1  pause active
m_axis_gpfc_pause_rank  out  PIFO_RANK_WIDTH  pause threshold rank
m_axis_occupancy  out  BUFFER_ADDR_WIDTH+1  current occupancy
m_axis_occ_error  out  1  sticky: overflow or underflow attempted

Behaviour:
- Reset (async assert, synchronous release to clk): occupancy=0, state IDLE, gpfc_valid=0, pause_rank=all ones, occ_error=0, interval counter=0.
- Occupancy (registered, updated on the edge after the event):
  - enq only: +1.
  - deq only: -1.
  - both or neither: unchanged.
  - Saturates at 2^BUFFER_ADDR_WIDTH and at 0.
  - An enq-only at full, or a deq-only at 0, leaves occupancy unchanged and sets occ_error, which stays set until reset.
  - enq+deq at full or at 0: no change, no error.
- FSM evaluates the registered occupancy; all outputs are registered.
- IDLE:
  - gpfc_valid=0, pause_rank=all ones.
  - If occupancy >= XOFF_THRESH: go to PAUSE, set pause_rank=PAUSE_RANK_INIT, gpfc_valid=1, counter=0.
  - Latency: gpfc_valid rises 2 edges after the enqueue that reaches XOFF.
- PAUSE:
  - Counter increments every cycle. A tick occurs when counter == UPDATE_INTERVAL-1; the counter then wraps to 0.
  - On a tick with occupancy >= XOFF_THRESH (tighten): pause_rank = PAUSE_RANK_MIN if pause_rank < PAUSE_RANK_MIN+RANK_STEP, else pause_rank-RANK_STEP. Compute in PIFO_RANK_WIDTH+1 bits; no wrap.
  - On a tick with occupancy < XON_THRESH (relax):
    - If pause_rank == PAUSE_RANK_INIT: go to IDLE (gpfc_valid=0, pause_rank=all ones).
    - Else pause_rank = min(pause_rank+RANK_STEP, PAUSE_RANK_INIT).
  - On a tick with XON_THRESH <= occupancy < XOFF_THRESH: hold.
  - No rank change between ticks.
- UPDATE_INTERVAL=1: every PAUSE cycle is a tick.
- Reset asserted mid-pause: outputs go to their reset values immediately (asynchronously).
- pause_rank must be stable while gpfc_valid=1, except on tick edges.

Test Plan:
- Reset, then 3072 enq-only cycles → occupancy=3072; gpfc_valid=1 and pause_rank=196608 exactly 2 edges after the 3072nd enqueue.
- Hold occupancy at 3100, UPDATE_INTERVAL=64 → rank 192512 after 64 cycles, 188416 after 128; with PAUSE_RANK_MIN=0, RANK_STEP=100000 and rank 196608, two ticks give 96608 then 0, then it stays at 0.
- From rank 188416, drain to 2000 → ticks give 192512, 196608, then IDLE with gpfc_valid=0 and rank=0x3FFFF.
- Occupancy 2500 while paused → rank unchanged across 5 ticks; state stays PAUSE.
- Fill to 4096, then enq-only → occupancy stays 4096, occ_error=1; simultaneous enq+deq at 4096 → no change. Deq-only at 0 → occ_error=1, occupancy stays 0.
- Assert rst mid-PAUSE between clock edges → gpfc_valid=0, occupancy=0, rank=all ones immediately; after release, refill to 3072 and see the PAUSE entry repeat with identical timing.
